mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified memory between the pipeline's fetch stage (IF) and memory stage (D).
- Arbitrates between the two requests, holds the memory interface stable for the whole transaction, and returns read data with a one-cycle ack.
- Generates the fetch and memory stall signals that the pipeline controller consumes.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter that lets the fetch stage (IF) and the memory stage (D) share one
// single-port, variable-latency memory. Define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ack,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_ack,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_m,
    output logic             bus_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUSY = 2'd1;
    localparam logic [1:0] S_D_BUSY  = 2'd2;
    localparam logic       G_IF      = 1'b0;
    localparam logic       G_D       = 1'b1;
    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic             if_ack_q, if_ack_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic             d_ack_q, d_ack_d;
    logic             if_elig_c, d_elig_c;
    logic             busy_end_c, timed_out_c;
    logic [WIDTH-1:0] end_data_c;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT);
`endif

    // A requester whose ack is showing this cycle has just been served and cannot be regranted yet
    assign if_elig_c = if_req & ~if_ack_q;
    assign d_elig_c  = d_req & ~d_ack_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        if_ack_d     = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_ack_d      = 1'b0;
        busy_end_c   = 1'b0;
        timed_out_c  = 1'b0;
        end_data_c   = mem_rdata;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        bus_err_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // D wins a conflict unless it was granted last, giving round-robin fairness
                if (d_elig_c && (!if_elig_c || last_grant_q == G_IF)) begin
                    state_d      = S_D_BUSY;
                    last_grant_d = G_D;
                    mem_en_d     = 1'b1;
                    mem_we_d     = d_we;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end else if (if_elig_c) begin
                    state_d      = S_IF_BUSY;
                    last_grant_d = G_IF;
                    mem_en_d     = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            S_IF_BUSY, S_D_BUSY: begin
                busy_end_c = mem_ready;
`ifdef ARB_TIMEOUT_EN
                if (!mem_ready) begin
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        busy_end_c  = 1'b1;
                        timed_out_c = 1'b1;
                        end_data_c  = '0;
                        bus_err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                if (busy_end_c) begin
                    state_d  = S_IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == S_IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = end_data_c;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q || timed_out_c) begin
                            d_rdata_d = end_data_c;
                        end
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= G_IF;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            d_rdata_q    <= '0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            if_ack_q     <= if_ack_d;
            d_rdata_q    <= d_rdata_d;
            d_ack_q      <= d_ack_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_f   = if_req & ~if_ack_q;
    assign stall_m   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus hand-written
// sequences for request drop, mid-transaction reset and the BUSY timeout.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_f;
    logic        stall_m;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_if_ack;
        logic [31:0] e_if_rdata;
        logic        e_d_ack;
        logic [31:0] e_d_rdata;
        logic        e_stall_f;
        logic        e_stall_m;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic rdy,
                       input logic [31:0] rd, input logic en, input logic we,
                       input logic [31:0] ma, input logic [31:0] mwd, input logic iak,
                       input logic [31:0] ird, input logic dak, input logic [31:0] drd,
                       input logic sf, input logic sm);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dw;
        v.d_addr = da;  v.d_wdata = dwd; v.mem_ready = rdy; v.mem_rdata = rd;
        v.e_en = en;    v.e_we = we;     v.e_addr = ma;  v.e_wdata = mwd;
        v.e_if_ack = iak; v.e_if_rdata = ird; v.e_d_ack = dak; v.e_d_rdata = drd;
        v.e_stall_f = sf; v.e_stall_m = sm;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;

        // Conflicts after reset: D, IF, D, IF with the ack cycle doubling as the idle gap
        add(1, 32'h40, 1, 0, 32'h80, 32'h99, 1, 32'hA0, 1, 0, 32'h80, 32'h99, 0, 32'h0,  0, 32'h0,  1, 1);
        add(1, 32'h40, 1, 0, 32'h80, 32'h99, 1, 32'hA1, 0, 0, 32'h80, 32'h99, 0, 32'h0,  1, 32'hA1, 1, 0);
        add(1, 32'h40, 1, 0, 32'h80, 32'h99, 1, 32'hA2, 1, 0, 32'h40, 32'h0,  0, 32'h0,  0, 32'hA1, 1, 1);
        add(1, 32'h40, 1, 0, 32'h80, 32'h99, 1, 32'hA3, 0, 0, 32'h40, 32'h0,  1, 32'hA3, 0, 32'hA1, 0, 1);
        add(1, 32'h40, 1, 0, 32'h80, 32'h99, 1, 32'hA4, 1, 0, 32'h80, 32'h99, 0, 32'hA3, 0, 32'hA1, 1, 1);
        add(1, 32'h40, 1, 0, 32'h80, 32'h99, 1, 32'hA5, 0, 0, 32'h80, 32'h99, 0, 32'hA3, 1, 32'hA5, 1, 0);
        add(1, 32'h40, 1, 0, 32'h80, 32'h99, 1, 32'hA6, 1, 0, 32'h40, 32'h0,  0, 32'hA3, 0, 32'hA5, 1, 1);
        add(1, 32'h40, 1, 0, 32'h80, 32'h99, 1, 32'hA7, 0, 0, 32'h40, 32'h0,  1, 32'hA7, 0, 32'hA5, 0, 1);
        add(0, 32'h40, 0, 0, 32'h80, 32'h99, 0, 32'h0,  0, 0, 32'h40, 32'h0,  0, 32'hA7, 0, 32'hA5, 0, 0);
        // Load via D alone with three BUSY cycles
        add(0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'hA7, 0, 32'hA5, 0, 1);
        add(0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'hA7, 0, 32'hA5, 0, 1);
        add(0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'h0, 1, 0, 32'h100, 32'h0, 0, 32'hA7, 0, 32'hA5, 0, 1);
        add(0, 32'h0, 1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, 0, 32'h100, 32'h0, 0, 32'hA7, 1, 32'hDEADBEEF, 0, 0);
        add(0, 32'h0, 0, 0, 32'h100, 32'h0, 0, 32'h0, 0, 0, 32'h100, 32'h0, 0, 32'hA7, 0, 32'hDEADBEEF, 0, 0);
        // Store leaves d_rdata untouched; mem_ready in IDLE is ignored
        add(0, 32'h0, 1, 1, 32'h20, 32'h12345678, 0, 32'h0, 1, 1, 32'h20, 32'h12345678, 0, 32'hA7, 0, 32'hDEADBEEF, 0, 1);
        add(0, 32'h0, 1, 1, 32'h20, 32'h12345678, 1, 32'hFFFF0000, 0, 0, 32'h20, 32'h12345678, 0, 32'hA7, 1, 32'hDEADBEEF, 0, 0);
        add(0, 32'h0, 0, 0, 32'h20, 32'h12345678, 1, 32'h55, 0, 0, 32'h20, 32'h12345678, 0, 32'hA7, 0, 32'hDEADBEEF, 0, 0);
        // Conflict with last grant D: IF goes first
        add(1, 32'h44, 1, 0, 32'h88, 32'h11, 0, 32'h0,  1, 0, 32'h44, 32'h0,  0, 32'hA7, 0, 32'hDEADBEEF, 1, 1);
        add(1, 32'h44, 1, 0, 32'h88, 32'h11, 1, 32'hB1, 0, 0, 32'h44, 32'h0,  1, 32'hB1, 0, 32'hDEADBEEF, 0, 1);
        add(0, 32'h44, 1, 0, 32'h88, 32'h11, 0, 32'h0,  1, 0, 32'h88, 32'h11, 0, 32'hB1, 0, 32'hDEADBEEF, 0, 1);
        add(0, 32'h44, 1, 0, 32'h88, 32'h11, 1, 32'hB3, 0, 0, 32'h88, 32'h11, 0, 32'hB1, 1, 32'hB3, 0, 0);
        add(0, 32'h44, 0, 0, 32'h88, 32'h11, 0, 32'h0,  0, 0, 32'h88, 32'h11, 0, 32'hB1, 0, 32'hB3, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst.mem_en", 32'(mem_en), 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.if_ack", 32'(if_ack), 32'h0);
        chk("rst.d_ack", 32'(d_ack), 32'h0);
        chk("rst.bus_err", 32'(bus_err), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req;     d_we = vecs[i].d_we;
            d_addr = vecs[i].d_addr;   d_wdata = vecs[i].d_wdata;
            mem_ready = vecs[i].mem_ready; mem_rdata = vecs[i].mem_rdata;
            step();
            chk($sformatf("v%0d.mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
            chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d.if_ack", i), 32'(if_ack), 32'(vecs[i].e_if_ack));
            chk($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("v%0d.d_ack", i), 32'(d_ack), 32'(vecs[i].e_d_ack));
            chk($sformatf("v%0d.d_rdata", i), d_rdata, vecs[i].e_d_rdata);
            chk($sformatf("v%0d.stall_f", i), 32'(stall_f), 32'(vecs[i].e_stall_f));
            chk($sformatf("v%0d.stall_m", i), 32'(stall_m), 32'(vecs[i].e_stall_m));
            chk($sformatf("v%0d.bus_err", i), 32'(bus_err), 32'h0);
        end

        // IF drops its request mid-transaction: ack still pulses, no regrant
        if_req = 1'b1; if_addr = 32'h400; d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("drop.grant_en", 32'(mem_en), 32'h1);
        chk("drop.grant_addr", mem_addr, 32'h400);
        if_req = 1'b0;
        step();
        chk("drop.busy_en", 32'(mem_en), 32'h1);
        chk("drop.stall_f", 32'(stall_f), 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h77;
        step();
        chk("drop.if_ack", 32'(if_ack), 32'h1);
        chk("drop.if_rdata", if_rdata, 32'h77);
        chk("drop.done_en", 32'(mem_en), 32'h0);
        mem_ready = 1'b0;
        step();
        chk("drop.ack_once", 32'(if_ack), 32'h0);
        chk("drop.no_regrant", 32'(mem_en), 32'h0);

        // Reset two cycles into IF_BUSY clears everything at once
        if_req = 1'b1; if_addr = 32'h300;
        step();
        chk("rmid.grant_en", 32'(mem_en), 32'h1);
        step();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rmid.mem_en", 32'(mem_en), 32'h0);
        chk("rmid.mem_addr", mem_addr, 32'h0);
        chk("rmid.if_rdata", if_rdata, 32'h0);
        chk("rmid.if_ack", 32'(if_ack), 32'h0);
        chk("rmid.stall_f", 32'(stall_f), 32'h1);
        @(negedge clk);
        chk("rmid.no_ack", 32'(if_ack), 32'h0);
        reset = 1'b1;
        step();
        chk("rmid.regrant_en", 32'(mem_en), 32'h1);
        chk("rmid.regrant_addr", mem_addr, 32'h300);
        mem_ready = 1'b1; mem_rdata = 32'hC0;
        step();
        chk("rmid.if_ack", 32'(if_ack), 32'h1);
        chk("rmid.if_rdata_new", if_rdata, 32'hC0);
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        // D load whose memory never answers
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        step();
        chk("to.grant_en", 32'(mem_en), 32'h1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("to.busy%0d_en", i), 32'(mem_en), 32'h1);
            chk($sformatf("to.busy%0d_err", i), 32'(bus_err), 32'h0);
        end
        step();
        chk("to.bus_err", 32'(bus_err), 32'h1);
        chk("to.d_ack", 32'(d_ack), 32'h1);
        chk("to.d_rdata", d_rdata, 32'h0);
        chk("to.mem_en", 32'(mem_en), 32'h0);
        d_req = 1'b0;
        step();
        chk("to.err_pulse", 32'(bus_err), 32'h0);
        chk("to.ack_pulse", 32'(d_ack), 32'h0);
        chk("to.idle_en", 32'(mem_en), 32'h0);
`else
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("to.wait%0d_en", i), 32'(mem_en), 32'h1);
            chk($sformatf("to.wait%0d_err", i), 32'(bus_err), 32'h0);
            chk($sformatf("to.wait%0d_ack", i), 32'(d_ack), 32'h0);
            chk($sformatf("to.wait%0d_stall", i), 32'(stall_m), 32'h1);
        end
        mem_ready = 1'b1; mem_rdata = 32'hE0;
        step();
        chk("to.late_ack", 32'(d_ack), 32'h1);
        chk("to.late_rdata", d_rdata, 32'hE0);
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("to.idle_en", 32'(mem_en), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
